// File: rtl/wb_shared_bus.sv
// Shared Wishbone bus: N masters arbitrated onto one path, address-decoded to M slaves.
// Latency: zero-cycle combinational forwarding once granted; one registered arbitration cycle.
// Backpressure: slave stall holds the master; a stall of TIMEOUT_CYCLES aborts with m_err.
module wb_shared_bus #(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 32,
    parameter int SELECT_WIDTH     = DATA_WIDTH / 8,
    parameter int NUM_MASTERS      = 4,
    parameter int NUM_SLAVES       = 19,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_ADDRESSES  = '0,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_ADDR_MASKS = '0,
    parameter int ARB_ROUND_ROBIN  = 0,
    parameter int TIMEOUT_CYCLES   = 1024,
    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    m_adr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_dat_w,
    input  logic [NUM_MASTERS*SELECT_WIDTH-1:0]  m_sel,
    input  logic [NUM_MASTERS-1:0]               m_we,
    input  logic [NUM_MASTERS-1:0]               m_stb,
    input  logic [NUM_MASTERS-1:0]               m_cyc,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_dat_r,
    output logic [NUM_MASTERS-1:0]               m_ack,
    output logic [NUM_MASTERS-1:0]               m_err,
    output logic [NUM_SLAVES*ADDR_WIDTH-1:0]     s_adr,
    output logic [NUM_SLAVES*DATA_WIDTH-1:0]     s_dat_w,
    output logic [NUM_SLAVES*SELECT_WIDTH-1:0]   s_sel,
    output logic [NUM_SLAVES-1:0]                s_we,
    output logic [NUM_SLAVES-1:0]                s_stb,
    output logic [NUM_SLAVES-1:0]                s_cyc,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0]     s_dat_r,
    input  logic [NUM_SLAVES-1:0]                s_ack,
    input  logic [NUM_SLAVES-1:0]                s_err,
    output logic                                 grant_valid,
    output logic [GW-1:0]                        grant_idx,
    output logic                                 timeout_pulse
);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {IDLE, OWNED, ABORT} state_t;

    state_t                  state_q, state_d;
    logic [GW-1:0]           grant_idx_q, grant_idx_d;
    logic [GW-1:0]           last_q, last_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    unm_err_q, unm_err_d;
    logic                    unm_done_q, unm_done_d;
    logic [ADDR_WIDTH-1:0]   unm_adr_q, unm_adr_d;

    logic [ADDR_WIDTH-1:0]   g_adr;
    logic [DATA_WIDTH-1:0]   g_dat_w;
    logic [SELECT_WIDTH-1:0] g_sel;
    logic                    g_we, g_stb, g_cyc;
    logic                    hit;
    logic [SW-1:0]           sel_idx;
    logic                    sel_ack, sel_err, g_err, unm_hit, tmo_hit;
    logic [DATA_WIDTH-1:0]   sel_dat;
    logic [GW-1:0]           win, rr_idx;

    always_comb begin
        g_adr   = m_adr[grant_idx_q*ADDR_WIDTH +: ADDR_WIDTH];
        g_dat_w = m_dat_w[grant_idx_q*DATA_WIDTH +: DATA_WIDTH];
        g_sel   = m_sel[grant_idx_q*SELECT_WIDTH +: SELECT_WIDTH];
        g_we    = m_we[grant_idx_q];
        g_stb   = m_stb[grant_idx_q];
        g_cyc   = m_cyc[grant_idx_q];
    end

    // Descending scan so the lowest matching slave is the one left standing.
    always_comb begin
        hit     = 1'b0;
        sel_idx = '0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if ((g_adr & SLAVE_ADDR_MASKS[k*ADDR_WIDTH +: ADDR_WIDTH]) ==
                (SLAVE_ADDRESSES[k*ADDR_WIDTH +: ADDR_WIDTH] & SLAVE_ADDR_MASKS[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
                hit     = 1'b1;
                sel_idx = SW'(k);
            end
        end
        sel_ack = hit & s_ack[sel_idx];
        sel_err = hit & s_err[sel_idx];
        sel_dat = s_dat_r[sel_idx*DATA_WIDTH +: DATA_WIDTH];
        g_err   = sel_err | unm_err_q;
        unm_hit = (state_q == OWNED) && g_cyc && g_stb && !hit;
    end

    always_comb begin
        win    = '0;
        rr_idx = '0;
        if (ARB_ROUND_ROBIN != 0) begin
            for (int off = NUM_MASTERS; off >= 1; off--) begin
                rr_idx = GW'((int'(last_q) + off) % NUM_MASTERS);
                if (m_cyc[rr_idx]) win = rr_idx;
            end
        end else begin
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                rr_idx = GW'(i);
                if (m_cyc[rr_idx]) win = rr_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_idx_q <= '0;
            last_q      <= GW'(NUM_MASTERS - 1);
            cnt_q       <= '0;
            unm_err_q   <= 1'b0;
            unm_done_q  <= 1'b0;
            unm_adr_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            unm_err_q   <= unm_err_d;
            unm_done_q  <= unm_done_d;
            unm_adr_q   <= unm_adr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        last_d      = last_q;
        cnt_d       = '0;
        tmo_hit     = 1'b0;
        // An unmapped strobe errors once, then re-arms on stb drop or a new address.
        unm_done_d  = unm_hit;
        unm_adr_d   = unm_hit ? g_adr : unm_adr_q;
        unm_err_d   = unm_hit && !(unm_done_q && (g_adr == unm_adr_q));
        case (state_q)
            IDLE: begin
                if (|m_cyc) begin
                    state_d     = OWNED;
                    grant_idx_d = win;
                    last_d      = win;
                end
            end
            OWNED: begin
                if (TIMEOUT_CYCLES > 0 && g_stb && !sel_ack && !g_err) begin
                    cnt_d   = (cnt_q == CW'(TIMEOUT_CYCLES)) ? cnt_q : cnt_q + 1'b1;
                    tmo_hit = (cnt_d == CW'(TIMEOUT_CYCLES));
                end
                if (tmo_hit)     state_d = ABORT;
                else if (!g_cyc) state_d = IDLE;
            end
            ABORT:   state_d = g_cyc ? OWNED : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_valid   = (state_q != IDLE);
        grant_idx     = grant_idx_q;
        timeout_pulse = (state_q == ABORT);
        s_adr         = {NUM_SLAVES{g_adr}};
        s_dat_w       = {NUM_SLAVES{g_dat_w}};
        s_sel         = {NUM_SLAVES{g_sel}};
        s_we          = {NUM_SLAVES{g_we}};
        s_cyc         = '0;
        s_stb         = '0;
        m_dat_r       = {NUM_MASTERS{sel_dat}};
        m_ack         = '0;
        m_err         = '0;
        if (state_q == OWNED) begin
            if (hit) begin
                s_cyc[sel_idx] = g_cyc;
                s_stb[sel_idx] = g_stb;
            end
            m_ack[grant_idx_q] = sel_ack;
            m_err[grant_idx_q] = g_err;
        end else if (state_q == ABORT) begin
            m_err[grant_idx_q] = 1'b1;
        end
    end
endmodule
